// File: rtl/edge_writer.sv
// edge_writer: queues (from, to, value) edge writes and drives them onto the shared tri-state BlockRam write bus.
// Optional feature macro: EDGE_WRITER_BOUNDS_CHECK_EN (drop out-of-range requests, sticky error flag).
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 16
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

module edge_writer #(
    parameter int unsigned MAX_NODES   = `DEFAULT_MAX_NODES,
    parameter int unsigned INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
    parameter int unsigned VALUE_WIDTH = `DEFAULT_VALUE_WIDTH,
    parameter int unsigned MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
    parameter int unsigned MDATA_WIDTH = `DEFAULT_MDATA_WIDTH,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [MADDR_WIDTH-1:0] base_address,
    input  logic [INDEX_WIDTH-1:0] number_of_nodes,
    input  logic                   write_enable,
    input  logic [INDEX_WIDTH-1:0] from_node,
    input  logic [INDEX_WIDTH-1:0] to_node,
    input  logic [VALUE_WIDTH-1:0] write_value,
    output logic                   write_accept,
    output logic [MADDR_WIDTH-1:0] mem_addr,
    output logic [MDATA_WIDTH-1:0] mem_write_data,
    output logic                   mem_write_enable,
    input  logic                   mem_write_ready,
    output logic                   idle,
    output logic                   error,
    output logic [15:0]            writes_done
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CALC_W = 2 * INDEX_WIDTH + MADDR_WIDTH;
    localparam int unsigned STRIDE = MADDR_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;
    state_t state;

    logic [MADDR_WIDTH-1:0] base_q;
    logic [INDEX_WIDTH-1:0] nodes_q;

    logic [INDEX_WIDTH-1:0] fifo_from  [FIFO_DEPTH];
    logic [INDEX_WIDTH-1:0] fifo_to    [FIFO_DEPTH];
    logic [VALUE_WIDTH-1:0] fifo_value [FIFO_DEPTH];
    logic [PTR_W:0]         wr_ptr;
    logic [PTR_W:0]         rd_ptr;
    logic [PTR_W-1:0]       wr_idx;
    logic [PTR_W-1:0]       rd_idx;
    logic                   full;
    logic                   empty;
    logic                   in_range;
    logic                   push;

    logic                   drive;
    logic [MADDR_WIDTH-1:0] addr_q;
    logic [MDATA_WIDTH-1:0] data_q;
    logic [MADDR_WIDTH-1:0] head_addr;
    logic [15:0]            done_count;

    // Matrix geometry is captured while reset is held and frozen afterwards;
    // N is saturated at MAX_NODES so the row stride never exceeds the matrix.
    always_ff @(posedge clock) begin
        if (reset) begin
            base_q <= base_address;
            if (32'(number_of_nodes) > MAX_NODES)
                nodes_q <= INDEX_WIDTH'(MAX_NODES);
            else
                nodes_q <= number_of_nodes;
        end
    end

    assign wr_idx = wr_ptr[PTR_W-1:0];
    assign rd_idx = rd_ptr[PTR_W-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);

    assign write_accept = !full && !reset;

`ifdef EDGE_WRITER_BOUNDS_CHECK_EN
    assign in_range = (from_node < nodes_q) && (to_node < nodes_q);
`else
    assign in_range = 1'b1;
`endif

    assign push = write_enable && write_accept && in_range;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (state == IDLE && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_from[wr_idx]  <= from_node;
            fifo_to[wr_idx]    <= to_node;
            fifo_value[wr_idx] <= write_value;
        end
    end

    always_comb begin
        head_addr = MADDR_WIDTH'(CALC_W'(base_q)
                  + (CALC_W'(fifo_from[rd_idx]) * CALC_W'(nodes_q) + CALC_W'(fifo_to[rd_idx]))
                  * CALC_W'(STRIDE));
    end

    // HOLD keeps the bus driven one extra cycle after ready; the return to IDLE
    // then gives one undriven turnaround cycle before the next pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            drive      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        addr_q <= head_addr;
                        data_q <= MDATA_WIDTH'(fifo_value[rd_idx]);
                        drive  <= 1'b1;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_write_ready === 1'b1)
                        state <= HOLD;
                end
                HOLD: begin
                    drive      <= 1'b0;
                    done_count <= done_count + 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    drive <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef EDGE_WRITER_BOUNDS_CHECK_EN
    logic error_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            error_q <= 1'b0;
        else if (write_enable && write_accept && !in_range)
            error_q <= 1'b1;
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign mem_write_enable = drive ? 1'b1   : 1'bz;
    assign mem_addr         = drive ? addr_q : 'z;
    assign mem_write_data   = drive ? data_q : 'z;

    assign idle        = empty && (state == IDLE);
    assign writes_done = done_count;
endmodule

// File: tb/tb_edge_writer.sv
// Directed self-checking bench for edge_writer with default parameters (32-bit addresses, stride 4).
module tb_edge_writer;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] base_address;
    logic [7:0]  number_of_nodes;
    logic        write_enable;
    logic [7:0]  from_node;
    logic [7:0]  to_node;
    logic [15:0] write_value;
    logic        write_accept;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic        mem_write_ready;
    logic        idle;
    logic        error;
    logic [15:0] writes_done;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    edge_writer dut (
        .clock            (clock),
        .reset            (reset),
        .base_address     (base_address),
        .number_of_nodes  (number_of_nodes),
        .write_enable     (write_enable),
        .from_node        (from_node),
        .to_node          (to_node),
        .write_value      (write_value),
        .write_accept     (write_accept),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_write_ready  (mem_write_ready),
        .idle             (idle),
        .error            (error),
        .writes_done      (writes_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] driven();
        return {31'b0, mem_write_enable === 1'b1};
    endfunction

    // Presents one request across a single rising edge; called and returns at a falling edge.
    task automatic push(input logic [7:0] f, input logic [7:0] t, input logic [15:0] v);
        write_enable = 1'b1;
        from_node    = f;
        to_node      = t;
        write_value  = v;
        @(negedge clock);
        write_enable = 1'b0;
    endtask

    task automatic wait_write(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_write_enable === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk(tag, {31'b0, ok}, 32'd1);
    endtask

    logic [31:0] exp_addr [6];
    logic [31:0] exp_data [6];

    initial begin
        int unsigned nw;
        bit prev;
        bit cur;
        bit drop_next;
        bit saw;

        reset           = 1'b1;
        base_address    = 32'h34;
        number_of_nodes = 8'd14;
        write_enable    = 1'b0;
        from_node       = '0;
        to_node         = '0;
        write_value     = '0;
        mem_write_ready = 1'b0;
        repeat (2) @(negedge clock);

        chk("rst_accept", {31'b0, write_accept}, 32'd0);
        chk("rst_idle", {31'b0, idle}, 32'd1);
        chk("rst_error", {31'b0, error}, 32'd0);
        chk("rst_done", {16'b0, writes_done}, 32'd0);
        chk("rst_bus", driven(), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("accept_after_rst", {31'b0, write_accept}, 32'd1);

        // Single write: (2,3) with N=14 -> index 31, address 0x34 + 31*4 = 0xB0
        push(8'd2, 8'd3, 16'h0204);
        chk("t1_not_yet", driven(), 32'd0);
        chk("t1_busy", {31'b0, idle}, 32'd0);
        @(negedge clock);
        chk("t1_we", driven(), 32'd1);
        chk("t1_addr", mem_addr, 32'h0000_00B0);
        chk("t1_data", mem_write_data, 32'h0000_0204);
        mem_write_ready = 1'b1;
        @(negedge clock);
        mem_write_ready = 1'b0;
        chk("t1_hold_we", driven(), 32'd1);
        chk("t1_hold_done", {16'b0, writes_done}, 32'd0);
        @(negedge clock);
        chk("t1_release", driven(), 32'd0);
        chk("t1_done", {16'b0, writes_done}, 32'd1);
        chk("t1_idle", {31'b0, idle}, 32'd1);

        // Six back-to-back requests with BlockRam stalled: 1 in flight + 4 queued
        for (int i = 0; i < 6; i++) begin
            exp_addr[i] = 32'h34 + 32'(i * 14 + i + 1) * 32'd4;
            exp_data[i] = 32'h100 + 32'(i);
        end
        write_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_accept%0d", i), {31'b0, write_accept}, 32'd1);
            from_node   = 8'(i);
            to_node     = 8'(i + 1);
            write_value = 16'(32'h100 + 32'(i));
            @(negedge clock);
        end
        chk("t2_full", {31'b0, write_accept}, 32'd0);
        from_node       = 8'd5;
        to_node         = 8'd6;
        write_value     = 16'h105;
        mem_write_ready = 1'b1;
        nw        = 0;
        prev      = 1'b0;
        drop_next = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (drop_next)
                write_enable = 1'b0;
            if (write_enable && write_accept)
                drop_next = 1'b1;
            cur = (mem_write_enable === 1'b1);
            if (cur && !prev) begin
                if (nw < 6) begin
                    chk($sformatf("t2_addr%0d", nw), mem_addr, exp_addr[nw]);
                    chk($sformatf("t2_data%0d", nw), mem_write_data, exp_data[nw]);
                end
                nw++;
            end
            prev = cur;
            if (nw >= 6 && !cur && !write_enable)
                break;
            @(negedge clock);
        end
        mem_write_ready = 1'b0;
        write_enable    = 1'b0;
        chk("t2_count", nw, 32'd6);
        chk("t2_done", {16'b0, writes_done}, 32'd7);
        chk("t2_idle", {31'b0, idle}, 32'd1);

        // Out-of-range request (14,0) with N=14
        chk("t5_accept", {31'b0, write_accept}, 32'd1);
        push(8'd14, 8'd0, 16'h0077);
        mem_write_ready = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (mem_write_enable === 1'b1)
                saw = 1'b1;
            @(negedge clock);
        end
        mem_write_ready = 1'b0;
`ifdef EDGE_WRITER_BOUNDS_CHECK_EN
        chk("t5_no_write", {31'b0, saw}, 32'd0);
        chk("t5_error", {31'b0, error}, 32'd1);
        chk("t5_done", {16'b0, writes_done}, 32'd7);
`else
        chk("t5_write", {31'b0, saw}, 32'd1);
        chk("t5_error", {31'b0, error}, 32'd0);
        chk("t5_done", {16'b0, writes_done}, 32'd8);
`endif

        // Reset in the middle of a stalled write with requests still queued
        push(8'd1, 8'd1, 16'h0011);
        wait_write("t3_wait");
        push(8'd2, 8'd2, 16'h0022);
        push(8'd3, 8'd3, 16'h0033);
        chk("t3_in_write", driven(), 32'd1);
        reset           = 1'b1;
        base_address    = 32'h100;
        number_of_nodes = 8'd5;
        #1;
        chk("t3_async_release", driven(), 32'd0);
        chk("t3_idle", {31'b0, idle}, 32'd1);
        chk("t3_done", {16'b0, writes_done}, 32'd0);
        chk("t3_accept", {31'b0, write_accept}, 32'd0);
        chk("t3_error", {31'b0, error}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        // Geometry changes after reset release must be ignored: (1,2) with N=5 -> 0x100 + 7*4
        base_address    = 32'hFFF;
        number_of_nodes = 8'd9;
        chk("t4_idle", {31'b0, idle}, 32'd1);
        push(8'd1, 8'd2, 16'h0055);
        wait_write("t4_wait");
        chk("t4_addr", mem_addr, 32'h0000_011C);
        chk("t4_data", mem_write_data, 32'h0000_0055);
        mem_write_ready = 1'b1;
        @(negedge clock);
        mem_write_ready = 1'b0;
        @(negedge clock);
        chk("t4_done", {16'b0, writes_done}, 32'd1);
        chk("t4_idle_end", {31'b0, idle}, 32'd1);
        chk("t4_release", driven(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
